config_regbank: RTL
===================

# config_regbank

Parametrised configuration register bank with double buffering. Writes land in shadow registers and become visible on the active outputs only on a commit, so multi-register settings change atomically. Commits apply either immediately or at the next `sync_i` event, such as a frame or conversion boundary. The block also carries a registered, parametrised read-back mux for status words. It sits between the host-side register interface and the analog/digital macros they configure.

## Interface
Parameters:
- `NUM_REGS`, default 4: number of configuration registers; must be ≥ 2.
- `DATA_W`, default 16: register width; must be a multiple of 8.
- `NUM_MUX`, default 8: number of read-back status inputs; must be ≥ 2.
- `MUX_W`, default 8: width of each status input.
- `SYNC_COMMIT`, default 0:
  - 0: commit applies the cycle after `commit_i`.
  - 1: commit waits for `sync_i`.

Derived widths: `AW` = $clog2(NUM_REGS), `MW` = $clog2(NUM_MUX), `BE_W` = DATA_W/8.

Ports:
- `clk_i` in 1: single clock; all state changes on its rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `reg_wr_i` in 1: write strobe, one write per asserted cycle.
- `reg_adr_i` in AW: target register index.
- `reg_dat_i` in DATA_W: write data.
- `reg_be_i` in BE_W: byte enables; bit k enables byte k of the word.
- `commit_i` in 1: commit request, sampled each cycle.
- `sync_i` in 1: commit sync event; used only when SYNC_COMMIT=1.
- `regs_o` out NUM_REGS*DATA_W: active registers, flattened; register i is at bits [i*DATA_W +: DATA_W].
- `shadow_o` out NUM_REGS*DATA_W: shadow registers, flattened with the same layout, for host read-back.
- `dirty_o` out 1: the shadow holds writes not yet committed.
- `pending_o` out 1: a commit is armed and waiting for `sync_i`.
- `commit_done_o` out 1: one-cycle pulse in the cycle the active registers update.
- `mux_adr_i` in MW: read-back select.
- `mux_i` in NUM_MUX*MUX_W: status inputs, flattened.
- `mux_o` out MUX_W: registered read-back data.

## Operation
- Shadow write:
  - When `reg_wr_i`=1 and `reg_adr_i` < NUM_REGS, each byte k with `reg_be_i[k]`=1 is replaced; disabled bytes are kept.
  - Address ≥ NUM_REGS: the write is ignored and `dirty_o` is unaffected.
  - A write with `reg_be_i`=0 is ignored.
- `dirty_o` is set by any accepted write and cleared by the copy. If an accepted write coincides with the copy cycle, `dirty_o` stays 1.
- Commit FSM states:
  - IDLE → COPY on `commit_i` when SYNC_COMMIT=0.
  - IDLE → ARMED on `commit_i` when SYNC_COMMIT=1.
  - ARMED → COPY on `sync_i`.
  - COPY → IDLE unconditionally.
- `pending_o`=1 only in ARMED.
- Copy (COPY state): all active registers load the shadow values as they were at the start of the COPY cycle. `commit_done_o`=1 for exactly that cycle.
- `commit_i` while ARMED or COPY is ignored; there is no queueing.
- `sync_i` in IDLE is ignored.
- `commit_i` and `sync_i` both asserted in IDLE with SYNC_COMMIT=1: enter ARMED only. That `sync_i` is not consumed, so the copy needs a later `sync_i`.
- Writes while ARMED update the shadow and are included in the eventual copy.
- Read-back:
  - `mux_o` is the `mux_adr_i`-selected `mux_i` word, registered.
  - `mux_adr_i` ≥ NUM_MUX yields 0.

## Timing
- Reset, in any state including ARMED or COPY:
  - shadow and active registers are 0, so `regs_o` and `shadow_o` are 0;
  - `dirty_o`, `pending_o`, `commit_done_o` and `mux_o` are 0;
  - the FSM returns to IDLE.
  - An armed commit is discarded.
- Write latency: `shadow_o` reflects the data 1 cycle after the `reg_wr_i` edge.
- SYNC_COMMIT=0: `commit_i` at edge N gives COPY during cycle N+1. `regs_o` changes at edge N+1 and is visible in cycle N+2.
- SYNC_COMMIT=1:
  - `commit_i` at edge N gives `pending_o`=1 from cycle N+1.
  - `sync_i` at edge M gives COPY in cycle M+1 and new `regs_o` from cycle M+2.
  - `pending_o` is 0 in the COPY cycle.
- Read-back latency: 1 cycle from `mux_adr_i`/`mux_i` to `mux_o`.

## Test plan
- Reset, then write reg1=0xA5A5 with `reg_be_i`=2'b11 and no commit → `shadow_o` reg1=0xA5A5, `regs_o` all 0, `dirty_o`=1.
- Byte enables: shadow reg0=0x1234, then write 0xFFFF with `reg_be_i`=2'b10 → reg0=0xFF34. Write to `reg_adr_i`=NUM_REGS (non-power-of-two config, NUM_REGS=3, `reg_adr_i`=3) → no change and `dirty_o` unaffected.
- SYNC_COMMIT=0: write reg0..reg3=1..4, pulse `commit_i` → `commit_done_o` one pulse, `regs_o`=4,3,2,1 (msb→lsb words) two cycles after the request, `dirty_o`=0.
- SYNC_COMMIT=1: commit, then write reg2=0x00FF while ARMED, extra `commit_i` ignored, then `sync_i` → `regs_o` reg2=0x00FF and exactly one `commit_done_o` pulse.
- Write coinciding with the COPY cycle → active register holds the old shadow value, shadow holds the new value, `dirty_o`=1. `rst_i` asserted while ARMED → all outputs 0, and a later `sync_i` produces no copy.
- Read-back: `mux_i` word k = k+0x10, sweep `mux_adr_i` 0..7 → `mux_o`=0x10..0x17, each one cycle late. With NUM_MUX=6 and `mux_adr_i`=6 → `mux_o`=0.

Source files
------------

// File: rtl/config_regbank.sv
// Double-buffered config register bank: byte-enabled shadow writes, atomic commit to active outputs.
// Latency: shadow 1 cycle after write; active regs load 1 cycle after the commit (or sync) edge; mux_o 1 cycle.
// Backpressure: none; writes and commits are accepted every cycle, commits while one is in flight are dropped.
module config_regbank #(
    parameter int NUM_REGS    = 4,
    parameter int DATA_W      = 16,
    parameter int NUM_MUX     = 8,
    parameter int MUX_W       = 8,
    parameter int SYNC_COMMIT = 0,
    localparam int AW         = $clog2(NUM_REGS),
    localparam int MW         = $clog2(NUM_MUX),
    localparam int BE_W       = DATA_W / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       reg_wr_i,
    input  logic [AW-1:0]              reg_adr_i,
    input  logic [DATA_W-1:0]          reg_dat_i,
    input  logic [BE_W-1:0]            reg_be_i,
    input  logic                       commit_i,
    input  logic                       sync_i,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS*DATA_W-1:0] shadow_o,
    output logic                       dirty_o,
    output logic                       pending_o,
    output logic                       commit_done_o,
    input  logic [MW-1:0]              mux_adr_i,
    input  logic [NUM_MUX*MUX_W-1:0]   mux_i,
    output logic [MUX_W-1:0]           mux_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_COPY} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shadow_q [NUM_REGS];
    logic [DATA_W-1:0] active_q [NUM_REGS];
    logic              dirty_q;
    logic [MUX_W-1:0]  mux_q, mux_sel;
    logic              wr_acc;
    logic              copy_en;

    // Out-of-range addresses and all-zero byte enables never touch the shadow or dirty flag.
    assign wr_acc = reg_wr_i && (int'(reg_adr_i) < NUM_REGS) && (|reg_be_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pending_o     = 1'b0;
        commit_done_o = 1'b0;
        copy_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A sync arriving with the commit is not consumed; arming needs a later sync.
                if (commit_i) state_d = (SYNC_COMMIT != 0) ? ST_ARMED : ST_COPY;
            end
            ST_ARMED: begin
                pending_o = 1'b1;
                if (sync_i) state_d = ST_COPY;
            end
            ST_COPY: begin
                commit_done_o = 1'b1;
                copy_en       = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_acc && (int'(reg_adr_i) == i)) begin
                    for (int k = 0; k < BE_W; k++) begin
                        if (reg_be_i[k]) shadow_q[i][k*8 +: 8] <= reg_dat_i[k*8 +: 8];
                    end
                end
            end
        end
    end

    // Active regs take the pre-edge shadow, so a write in the copy cycle lands only in the shadow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) active_q[i] <= '0;
        end else if (copy_en) begin
            for (int i = 0; i < NUM_REGS; i++) active_q[i] <= shadow_q[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dirty_q <= 1'b0;
        end else if (wr_acc) begin
            dirty_q <= 1'b1;
        end else if (copy_en) begin
            dirty_q <= 1'b0;
        end
    end

    always_comb begin
        mux_sel = '0;
        for (int k = 0; k < NUM_MUX; k++) begin
            if (int'(mux_adr_i) == k) mux_sel = mux_i[k*MUX_W +: MUX_W];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mux_q <= '0;
        end else begin
            mux_q <= mux_sel;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*DATA_W +: DATA_W]   = active_q[g];
        assign shadow_o[g*DATA_W +: DATA_W] = shadow_q[g];
    end

    assign dirty_o = dirty_q;
    assign mux_o   = mux_q;

endmodule
